// File: rtl/givens_matrix_writer.sv
// Builds the rows of an N x N Givens rotation matrix for plane (p, q) from CORDIC cos/sin
// and writes them one row per cycle into Givens BRAM port A.
module givens_matrix_writer #(
   parameter int N    = 4,
   parameter int DW   = 8,
   parameter int FRAC = 6,
   parameter int IDXW = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                full_write,
   input  logic [IDXW-1:0]     p,
   input  logic [IDXW-1:0]     q,
   input  logic [DW-1:0]       cos_data,
   input  logic [DW-1:0]       sin_data,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic                ena_givens,
   output logic                wea_givens,
   output logic [IDXW-1:0]     addra_givens,
   output logic [N*DW-1:0]     dina_givens
);

   localparam logic [DW-1:0] ONE     = DW'(1) << FRAC;
   localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] MOST_POS = {1'b0, {(DW-1){1'b1}}};

   typedef enum logic {S_IDLE, S_WRITE} state_t;

   state_t              r_state, w_state_nxt;
   logic [IDXW-1:0]     r_row, w_row_nxt;
   logic [IDXW-1:0]     r_p, r_q;
   logic [DW-1:0]       r_cos, r_sin;
   logic                r_full;
   logic                r_wr, r_done, r_err;
   logic [IDXW-1:0]     r_addr;
   logic [N*DW-1:0]     r_din;

   logic                w_idle, w_bad, w_last;
   logic [IDXW-1:0]     w_p, w_q, w_lo, w_hi;
   logic [DW-1:0]       w_cos, w_sin;
   logic                w_wr_nxt, w_done_nxt, w_err_nxt;
   logic [N*DW-1:0]     w_din_nxt;

   function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] x);
      return (x == MOST_NEG) ? MOST_POS : DW'(-x);
   endfunction

   function automatic logic [N*DW-1:0] row_data(input logic [IDXW-1:0] row,
                                                 input logic [IDXW-1:0] rp,
                                                 input logic [IDXW-1:0] rq,
                                                 input logic [DW-1:0]   c_v,
                                                 input logic [DW-1:0]   s_v);
      logic [N*DW-1:0] d;
      d = '0;
      for (int c = 0; c < N; c++) begin
         if (IDXW'(c) == row) d[(N-1-c)*DW +: DW] = ONE;
         if (row == rp) begin
            if (IDXW'(c) == rp)      d[(N-1-c)*DW +: DW] = c_v;
            else if (IDXW'(c) == rq) d[(N-1-c)*DW +: DW] = s_v;
         end else if (row == rq) begin
            if (IDXW'(c) == rq)      d[(N-1-c)*DW +: DW] = c_v;
            else if (IDXW'(c) == rp) d[(N-1-c)*DW +: DW] = neg_sat(s_v);
         end
      end
      return d;
   endfunction

   // While idle the live inputs feed the first row; afterwards only latched copies are used.
   assign w_idle = (r_state == S_IDLE);
   assign w_p    = w_idle ? p        : r_p;
   assign w_q    = w_idle ? q        : r_q;
   assign w_cos  = w_idle ? cos_data : r_cos;
   assign w_sin  = w_idle ? sin_data : r_sin;
   assign w_lo   = (w_p < w_q) ? w_p : w_q;
   assign w_hi   = (w_p < w_q) ? w_q : w_p;
   assign w_bad  = (p == q) || (32'(p) >= 32'(N)) || (32'(q) >= 32'(N));
   assign w_last = r_full ? (r_row == IDXW'(N-1)) : (r_row == w_hi);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_p     <= '0;
         r_q     <= '0;
         r_cos   <= '0;
         r_sin   <= '0;
         r_full  <= 1'b0;
         r_wr    <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= '0;
         r_din   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         if (w_idle && start) begin
            r_p    <= p;
            r_q    <= q;
            r_cos  <= cos_data;
            r_sin  <= sin_data;
            r_full <= full_write;
         end
         r_wr   <= w_wr_nxt;
         r_done <= w_done_nxt;
         r_err  <= w_err_nxt;
         if (w_wr_nxt) begin
            r_addr <= w_row_nxt;
            r_din  <= w_din_nxt;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      case (r_state)
         S_IDLE: begin
            if (start && !w_bad) begin
               w_state_nxt = S_WRITE;
               w_row_nxt   = full_write ? '0 : w_lo;
            end
         end
         S_WRITE: begin
            if (w_last) w_state_nxt = S_IDLE;
            else        w_row_nxt   = r_full ? r_row + 1'b1 : w_hi;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_wr_nxt   = (w_state_nxt == S_WRITE);
      w_done_nxt = (r_state == S_WRITE) && w_last;
      w_err_nxt  = w_idle && start && w_bad;
      w_din_nxt  = row_data(w_row_nxt, w_p, w_q, w_cos, w_sin);
   end

   assign busy         = r_wr;
   assign ena_givens   = r_wr;
   assign wea_givens   = r_wr;
   assign done         = r_done;
   assign err          = r_err;
   assign addra_givens = r_addr;
   assign dina_givens  = r_din;

endmodule

// File: doc/givens_matrix_writer.md
Name: givens_matrix_writer

Overview:
- Parametrised, handshaked successor to the Givens-matrix write controller.
- Takes a rotation plane (p, q) and CORDIC cos/sin results, then builds the rows of an N×N Givens rotation matrix, including identity rows.
- Writes rows one per cycle into the Givens BRAM port A.
- Sits between the CORDIC engine and the Givens matrix memory used by the Jacobi rotation stage.

Parameters:
- N, 4: matrix dimension, number of rows and lanes; N >= 2.
- DW, 8: element width, signed two's complement.
- FRAC, 6: fractional bits of the element fixed-point format; ONE = 2^FRAC (must be < 2^(DW-1)).
- IDXW, $clog2(N): width of the index and address.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; accepted only when busy=0
- full_write  in  1  1 = write all N rows; 0 = write only rows p and q
- p  in  IDXW  rotation row index
- q  in  IDXW  rotation column index
- cos_data  in  DW  signed cosine from CORDIC
- sin_data  in  DW  signed sine from CORDIC
- busy  out  1  high while row writes are being presented
- done  out  1  one-cycle pulse after the last write
- err  out  1  one-cycle pulse on a rejected request
- ena_givens  out  1  BRAM enable
- wea_givens  out  1  BRAM write enable
- addra_givens  out  IDXW  BRAM row address
- dina_givens  out  N*DW  row data; lane c (column c) occupies bits [(N-c)*DW-1 : (N-c-1)*DW], so column 0 is in the MSBs

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs are registered and are 0 on reset. State is IDLE.
- Reset mid-operation: aborts immediately. No further writes, no done pulse.
- States: IDLE, WRITE.
- Request validation: on an edge with start=1 and busy=0, the block latches p, q, cos, sin and full_write.
  - If p==q, or p>=N, or q>=N: err=1 for one cycle, no write, stay IDLE.
  - Otherwise go to WRITE.
- Matrix contents G:
  - G[p][p] = cos, G[q][q] = cos.
  - G[p][q] = sin, G[q][p] = neg(sin).
  - G[k][k] = ONE for k ∉ {p, q}.
  - All other elements are 0.
- neg(x): two's complement negate, saturated. neg(-2^(DW-1)) = 2^(DW-1)-1.
- Row order:
  - full_write=1: rows 0, 1, …, N-1.
  - full_write=0: row min(p,q), then row max(p,q).
- Write timing:
  - On the accepting edge, the first row is registered: ena=wea=1, addr=row, din=row data, busy=1.
  - Each following edge registers the next row.
  - On the edge after the last row: ena=wea=0, busy=0, done=1 for one cycle, state returns to IDLE.
- Latency:
  - Partial request: writes in cycles k, k+1; done in cycle k+2.
  - Full request: writes in cycles k..k+N-1; done in cycle k+N.
- Back-to-back: start is accepted in the done cycle, since busy=0 there. The new first row appears in that same cycle's following register state.
- start while busy=1 is ignored; it is neither queued nor flagged.
- Input changes on p, q, cos, sin and full_write after acceptance do not affect the operation in flight.
- Outside writes: addra and dina hold their last value when ena=0. Verification checks them only when ena=1.

Test Plan:
- Full write, N=4, DW=8, FRAC=6, p=1, q=3, cos=0x2D, sin=0x2D → four consecutive writes:
  - addr0 = 0x40000000
  - addr1 = 0x002D002D
  - addr2 = 0x00004000
  - addr3 = 0x00D3002D
  - done pulses in the cycle after addr3; busy high exactly 4 cycles.
- Partial write, p=2, q=0, cos=0x2D, sin=0x2D, full_write=0 → exactly two writes:
  - addr0 = 0x2D00D300
  - addr2 = 0x2D002D00
  - done in the third cycle.
- Saturation: p=0, q=1, sin=0x80, cos=0x00, full_write=0 → addr0 = 0x00800000, addr1 = 0x7F000000.
- Error: p=q=1 → err=1 for one cycle, ena/wea never asserted, busy stays 0, no done.
- Handshake:
  - start held high continuously during a full write → second request accepted only in the done cycle; rows restart at 0 with no gap cycle.
  - A start pulse mid-write is ignored.
- Reset: assert rst during the 2nd row of a full write → next cycle all outputs 0, no further writes, no done; a new start afterwards completes normally.
